// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS core support logic.
// Boot loader items:
//   boot_state_t    : loader FSM state encoding
//   BOOT_HDR_BYTES  : header length in bytes (big-endian word count)
//   BOOT_WORD_BYTES : bytes packed into one instruction word
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [2:0] {
    BOOT_HDR,
    BOOT_LOAD,
    BOOT_CSUM,
    BOOT_DONE,
    BOOT_ERR
  } boot_state_t;

  localparam int BOOT_HDR_BYTES  = 2;
  localparam int BOOT_WORD_BYTES = 4;

endpackage

// File: rtl/boot_word_packer.sv
// -----------------------------------------------------------------------------
// boot_word_packer
// Packs a byte stream into 32-bit words, big-endian (first byte -> [31:24]).
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-low reset
//   byte_in    : byte to pack
//   byte_en    : byte_in is consumed this cycle
//   word_out   : packed word, valid while word_valid is high
//   word_valid : one-cycle pulse the cycle after the 4th byte of a word
// -----------------------------------------------------------------------------
module boot_word_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic [31:0] word_out,
  output logic        word_valid
);

  localparam logic [1:0] LAST_LANE = 2'(BOOT_WORD_BYTES - 1);

  logic [1:0] byte_cnt;

  // The shift register itself is the output: after the 4th shift it holds the
  // complete word for exactly the pulse cycle. A byte taken during the pulse
  // starts the next word on the following edge without disturbing this one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_out   <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && (byte_cnt == LAST_LANE);
      if (byte_en) begin
        word_out <= {word_out[23:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// -----------------------------------------------------------------------------
// mips_boot_loader
// Loads a program image from a byte stream into instruction memory, holding
// the MIPS core in reset until the image is complete.
// Stream: 2-byte big-endian word count N, then 4*N payload bytes (big-endian
// words), then one XOR checksum byte when BOOT_CHECKSUM_EN is defined.
// Optional feature macro: BOOT_CHECKSUM_EN (running XOR + trailing check byte).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// BOOT_HDR  | collecting the 2 header bytes (word count N)
// BOOT_LOAD | collecting payload bytes, writing one word per 4 bytes
// BOOT_CSUM | waiting for the trailing checksum byte (BOOT_CHECKSUM_EN only)
// BOOT_DONE | image loaded, core released, further bytes ignored
// BOOT_ERR  | protocol error, core held in reset
//
// Ports:
//   clk, rst            : clock and synchronous active-low reset
//   rx_data/valid/ready : byte stream handshake
//   imem_we/addr/wdata  : instruction memory write port (one-cycle strobe)
//   core_rst            : active-high reset to the core
//   boot_done/boot_err  : sticky status flags
//   words_loaded        : words written so far
// -----------------------------------------------------------------------------
module mips_boot_loader
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int               BL_W      = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  boot_state_t       state;
  logic              hdr_cnt;
  logic [7:0]        hdr_hi;
  logic [ADDR_W:0]   n_words;
  logic [BL_W-1:0]   bytes_left;
  logic [ADDR_W-1:0] addr;

  logic              accept;
  logic [15:0]       n_hdr;
  logic              pk_en;
  logic              pk_valid;
  logic [31:0]       pk_word;
  logic              last_word;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept    = rx_valid && rx_ready;
  assign n_hdr     = {hdr_hi, rx_data};
  // Payload budget gates the packer so stray bytes after the image are dropped.
  assign pk_en     = accept && (state == BOOT_LOAD) && (bytes_left != '0);
  assign last_word = (words_loaded + (ADDR_W+1)'(1)) == n_words;

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (rx_data),
    .byte_en    (pk_en),
    .word_out   (pk_word),
    .word_valid (pk_valid)
  );

  assign imem_we    = pk_valid;
  assign imem_addr  = addr;
  assign imem_wdata = DATA_W'(pk_word);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= BOOT_HDR;
      hdr_cnt      <= 1'b0;
      hdr_hi       <= '0;
      n_words      <= '0;
      bytes_left   <= '0;
      addr         <= '0;
      words_loaded <= '0;
      rx_ready     <= 1'b0;
      core_rst     <= 1'b1;
      boot_done    <= 1'b0;
      boot_err     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      // The final write can land in BOOT_CSUM, so writes are tracked in every state.
      if (pk_valid) begin
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
        if (addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
      end

      case (state)
        BOOT_HDR: begin
          rx_ready <= 1'b1;
          if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (!hdr_cnt) begin
              hdr_hi  <= rx_data;
              hdr_cnt <= 1'b1;
            end else begin
              hdr_cnt <= 1'b0;
              if (n_hdr > 16'(IMEM_DEPTH)) begin
                state    <= BOOT_ERR;
                rx_ready <= 1'b0;
                boot_err <= 1'b1;
              end else begin
                n_words    <= n_hdr[ADDR_W:0];
                bytes_left <= {n_hdr[ADDR_W:0], 2'b00};
                if (n_hdr == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                  state <= BOOT_CSUM;
`else
                  state     <= BOOT_DONE;
                  rx_ready  <= 1'b0;
                  core_rst  <= 1'b0;
                  boot_done <= 1'b1;
`endif
                end else begin
                  state <= BOOT_LOAD;
                end
              end
            end
          end
        end

        BOOT_LOAD: begin
          rx_ready <= 1'b1;
          if (pk_en) begin
            bytes_left <= bytes_left - BL_W'(1);
`ifdef BOOT_CHECKSUM_EN
            csum <= csum ^ rx_data;
            // Leave on the last payload byte so a checksum byte arriving during
            // the final write pulse is not fed to the packer.
            if (bytes_left == BL_W'(1)) state <= BOOT_CSUM;
`endif
          end
`ifndef BOOT_CHECKSUM_EN
          if (pk_valid && last_word) begin
            state     <= BOOT_DONE;
            rx_ready  <= 1'b0;
            core_rst  <= 1'b0;
            boot_done <= 1'b1;
          end
`endif
        end

`ifdef BOOT_CHECKSUM_EN
        BOOT_CSUM: begin
          rx_ready <= 1'b1;
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= BOOT_DONE;
              core_rst  <= 1'b0;
              boot_done <= 1'b1;
            end else begin
              state    <= BOOT_ERR;
              boot_err <= 1'b1;
            end
          end
        end
`endif

        BOOT_DONE: begin
          rx_ready  <= 1'b0;
          core_rst  <= 1'b0;
          boot_done <= 1'b1;
        end

        BOOT_ERR: begin
          rx_ready <= 1'b0;
          core_rst <= 1'b1;
          boot_err <= 1'b1;
        end

        default: begin
          state    <= BOOT_ERR;
          rx_ready <= 1'b0;
          boot_err <= 1'b1;
        end
      endcase
    end
  end

endmodule
